// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input controller: FSM states,
// default sizes and the header field layout {len[7:2], addr[1:0]}.
package router_pkg;

    localparam int DATA_W      = 8;
    localparam int NUM_PORTS   = 3;
    localparam int TIMEOUT_DEF = 30;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        CHECK,
        DROP
    } state_t;

endpackage

// File: rtl/router_sft_timer.sv
// Read-timeout watchdog for one output FIFO: pulses sft_rst for one cycle
// after TIMEOUT consecutive cycles of valid data that nobody reads.
module router_sft_timer import router_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic read_enb,
    output logic sft_rst
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            sft_rst <= 1'b0;
        end else begin
            sft_rst <= 1'b0;
            if (vld && !read_enb) begin
                if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    cnt     <= '0;
                    sft_rst <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Input-side controller of the 1x3 router: decodes the header, sequences
// FIFO writes through a single held write register, checks parity/length.
module router_ctrl #(
    parameter int DATA_W    = router_pkg::DATA_W,
    parameter int NUM_PORTS = router_pkg::NUM_PORTS,
    parameter int TIMEOUT   = router_pkg::TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 busy,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] fifo_wr_en,
    output logic [DATA_W-1:0]    fifo_wr_data,
    output logic                 lfd_stat,
    output logic [NUM_PORTS-1:0] sft_rst,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic                 err
);
    import router_pkg::*;

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    hdr_reg;
    logic [DATA_W-1:0]    parity;
    logic [1:0]           dest;
    logic [LEN_W-1:0]     count;
    logic [1:0]           hdr_addr;
    logic [NUM_PORTS-1:0] dest_oh;
    logic                 pending;
    logic                 full_dest;
    logic                 retire;
    logic                 accept;
    logic                 abort;

    assign vld_out   = ~fifo_empty;
    assign hdr_addr  = data_in[ADDR_MSB:ADDR_LSB];
    assign pending   = |fifo_wr_en;
    assign full_dest = fifo_full[dest];
    assign retire    = pending && !full_dest;
    assign accept    = (state == LOAD_DATA) && !(pending && full_dest);
    assign lfd_stat  = (state == LOAD_FIRST);
    assign abort     = sft_rst[dest] &&
                       (state == LOAD_FIRST || state == LOAD_DATA || state == CHECK);

    always_comb begin
        dest_oh       = '0;
        dest_oh[dest] = 1'b1;
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wd
        router_sft_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld_out[i]),
            .read_enb (read_enb[i]),
            .sft_rst  (sft_rst[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (hdr_addr == ADDR_INVALID)   state_nxt = DROP;
                    else if (!fifo_empty[hdr_addr]) state_nxt = WAIT_EMPTY;
                    else                            state_nxt = LOAD_FIRST;
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[dest]) state_nxt = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy      = 1'b1;
                state_nxt = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = pending && full_dest;
                if (accept && !pkt_valid) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (!pending || !full_dest) state_nxt = IDLE;
            end
            DROP: begin
                if (!pkt_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = pkt_valid ? DROP : IDLE;
    end

    // Write register: a pending write holds until the destination is not full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_reg      <= '0;
            dest         <= '0;
            parity       <= '0;
            count        <= '0;
            err          <= 1'b0;
            fifo_wr_en   <= '0;
            fifo_wr_data <= '0;
        end else begin
            if (retire) fifo_wr_en <= '0;
            case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        hdr_reg <= data_in;
                        dest    <= hdr_addr;
                        parity  <= data_in;
                        count   <= '0;
                        err     <= (hdr_addr == ADDR_INVALID);
                    end
                end
                LOAD_FIRST: begin
                    fifo_wr_en   <= dest_oh;
                    fifo_wr_data <= hdr_reg;
                end
                LOAD_DATA: begin
                    if (accept) begin
                        fifo_wr_en   <= dest_oh;
                        fifo_wr_data <= data_in;
                        parity       <= parity ^ data_in;
                        if (pkt_valid && count != '1) count <= count + 1'b1;
                    end
                end
                CHECK: begin
                    if (!pending || !full_dest)
                        err <= (parity != '0) || (count != hdr_reg[LEN_MSB:LEN_LSB]);
                end
                default: ;
            endcase
            if (abort) begin
                fifo_wr_en <= '0;
                err        <= 1'b1;
            end
        end
    end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
- Input-side controller of the 1x3 router.
- Accepts the byte-serial packet stream from the source, decodes the header's destination, and sequences writes into one of the three output FIFOs.
- Drives the FIFOs' lfd_stat and wr_en, checks packet parity/length, and back-pressures the source with busy.
- Runs per-port read-timeout watchdogs that issue sft_rst to the FIFOs.

Parameters:
- DATA_W, 8, byte width of data_in / fifo_wr_data.
- NUM_PORTS, 3, number of destination FIFOs. The address map is fixed for 3.
- TIMEOUT, 30, consecutive unread cycles on a non-empty FIFO before sft_rst.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- pkt_valid  in  1  high for header and payload bytes; low in the parity-byte cycle.
- data_in  in  DATA_W  packet byte. Header = {len[7:2], addr[1:0]}.
- busy  out  1  source must hold data_in/pkt_valid while high.
- fifo_full  in  NUM_PORTS  per-FIFO full.
- fifo_empty  in  NUM_PORTS  per-FIFO empty.
- read_enb  in  NUM_PORTS  downstream read strobes.
- fifo_wr_en  out  NUM_PORTS  one-hot FIFO write enable (registered).
- fifo_wr_data  out  DATA_W  FIFO write data (registered).
- lfd_stat  out  1  header marker; high one cycle before the header write.
- sft_rst  out  NUM_PORTS  one-cycle per-FIFO soft reset (registered).
- vld_out  out  NUM_PORTS  ~fifo_empty (combinational).
- err  out  1  packet error flag (registered).

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, fifo_wr_en=0, fifo_wr_data=0, lfd_stat=0, sft_rst=0, err=0; timers, parity and counters cleared. The same applies mid-packet; partial packets are abandoned.
- States: IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK, DROP.
- IDLE, pkt_valid=1:
  - addr==3 -> DROP, err<=1.
  - fifo_empty[addr]=0 -> WAIT_EMPTY.
  - otherwise -> LOAD_FIRST.
  - In all cases latch header into hdr_reg/dest, parity<=header, count<=0, and clear err unless addr==3.
- WAIT_EMPTY: busy=1. When fifo_empty[dest]=1 -> LOAD_FIRST.
- LOAD_FIRST (exactly 1 cycle): lfd_stat=1, busy=1. Register fifo_wr_en<=onehot(dest), fifo_wr_data<=hdr_reg -> LOAD_DATA. The FIFO registers lfd internally, so the header lands with lfd=1.
- Write register:
  - A pending write is held (wr_en and data stable) while fifo_full[dest]=1.
  - It retires in the cycle where fifo_full[dest]=0.
  - No byte is ever dropped or reordered.
- LOAD_DATA:
  - busy = pending && fifo_full[dest].
  - Byte accepted on each cycle busy=0. It becomes the next pending write, parity^=data_in.
  - pkt_valid=1 -> payload, count++ (saturates at 63).
  - pkt_valid=0 -> parity byte; write it too -> CHECK.
- CHECK: busy=1 until the pending write retires. Then err<=(parity!=0) || (count!=len) -> IDLE. Total writes per good packet = len+2.
- DROP: busy=0, no writes. Consume bytes until the pkt_valid=0 byte -> IDLE. err stays 1.
- err holds until the next accepted header.
- Watchdog per port i:
  - Counter increments when vld_out[i] && !read_enb[i]; clears otherwise.
  - On reaching TIMEOUT: sft_rst[i]<=1 for one cycle, counter<=0.
- Watchdog abort: if sft_rst[dest] fires while in LOAD_FIRST/LOAD_DATA/CHECK, drop the pending write, err<=1, state -> DROP if pkt_valid=1, else IDLE.
- Header in IDLE is accepted only with no pending write (guaranteed by CHECK).

Decomposition:
- Shared package router_pkg: state enum, DATA_W, NUM_PORTS, ADDR_INVALID=2'b11, default TIMEOUT, header field slice constants.
- Sub-module router_sft_timer: one-port watchdog, instantiated NUM_PORTS times.

Test Plan:
- Good packet: header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D, fifo_empty=3'b111.
  - lfd_stat one cycle before the header write.
  - fifo_wr_en=3'b010 for 5 writes: 0x0D,0x11,0x22,0x33,0x0D.
  - err=0; busy high only in LOAD_FIRST/CHECK.
- Parity error: same packet with parity 0x00 -> same 5 writes, err=1 after CHECK. Payload of 2 bytes with len 3 -> err=1.
- Full stall: fifo_full[1]=1 for 4 cycles mid-payload -> busy=1 those cycles, held byte written once on release, order 0x11,0x22,0x33 preserved.
- Wait for empty: header 0x06 (addr 2) with fifo_empty[2]=0 -> busy=1, no writes until fifo_empty[2]=1, then lfd_stat then header write.
- Watchdog: fifo_empty[0]=0, read_enb[0]=0.
  - Exactly one sft_rst[0] pulse after 30 cycles.
  - A read_enb[0] pulse at cycle 29 -> no pulse, count restarts.
- Drop and reset: header 0x07 (addr 3) -> zero writes, err=1, busy=0. Then rst low mid-payload of a good packet -> all outputs 0 immediately, state IDLE.
